// File: rtl/npc_mc_sequencer.sv
// Multi-cycle NPC control core: sequences fetch, execute, memory and writeback
// over valid/ready memory handshakes and owns PC, instruction latch, halt and counters.
module npc_mc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              CNT_W    = 64,
    parameter int unsigned     TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req,
    input  logic             ifu_ready,
    input  logic             ifu_rvalid,
    input  logic [31:0]      ifu_rdata,
    input  logic             idu_is_load,
    input  logic             idu_is_store,
    input  logic             idu_is_ebreak,
    input  logic             idu_illegal,
    input  logic             idu_rd_wen,
    input  logic [XLEN-1:0]  dnpc,
    output logic             lsu_req,
    output logic             lsu_wen,
    input  logic             lsu_ready,
    input  logic             lsu_rvalid,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      inst,
    output logic             gpr_wen,
    output logic             commit,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    typedef enum logic [2:0] {
        S_IF_REQ   = 3'd0,
        S_IF_WAIT  = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd7
    } state_t;

    localparam int WD_W = 32;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [1:0]       halt_code_q, halt_code_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic [WD_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WD_W-1:0]  wait_inc;
    logic             wd_expire;

    // wait_inc is the number of cycles spent in the current wait phase including this one
    assign wait_inc  = wait_cnt_q + WD_W'(1);
    assign wd_expire = (TIMEOUT != 0) && (wait_inc >= WD_W'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        halt_code_d   = halt_code_q;
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = instret_cnt_q;
        wait_cnt_d    = '0;
        case (state_q)
            S_IF_REQ: begin
                wait_cnt_d = wait_inc;
                if (ifu_ready) begin
                    if (ifu_rvalid) begin
                        inst_d  = ifu_rdata;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IF_WAIT;
                    end
                end else if (wd_expire) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'd2;
                end
            end
            S_IF_WAIT: begin
                wait_cnt_d = wait_inc;
                if (ifu_rvalid) begin
                    inst_d  = ifu_rdata;
                    state_d = S_EXEC;
                end else if (wd_expire) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'd2;
                end
            end
            S_EXEC: begin
                if (idu_is_ebreak) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'd0;
                end else if (idu_illegal) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'd1;
                end else if (idu_is_load || idu_is_store) begin
                    state_d = S_MEM_REQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM_REQ: begin
                wait_cnt_d = wait_inc;
                if (lsu_ready) begin
                    state_d = lsu_rvalid ? S_WB : S_MEM_WAIT;
                end else if (wd_expire) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'd2;
                end
            end
            S_MEM_WAIT: begin
                wait_cnt_d = wait_inc;
                if (lsu_rvalid) begin
                    state_d = S_WB;
                end else if (wd_expire) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'd2;
                end
            end
            S_WB: begin
                pc_d          = dnpc;
                instret_cnt_d = instret_cnt_q + CNT_W'(1);
                state_d       = S_IF_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IF_REQ;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            halt_code_q   <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            halt_code_q   <= halt_code_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Requests and strobes are masked while reset is held so nothing leaks mid-reset
    assign ifu_req     = (state_q == S_IF_REQ) && !rst;
    assign lsu_req     = (state_q == S_MEM_REQ) && !rst;
    assign lsu_wen     = lsu_req && idu_is_store;
    assign commit      = (state_q == S_WB) && !rst;
    assign gpr_wen     = commit && idu_rd_wen && !idu_is_store;
    assign halt        = (state_q == S_HALT);
    assign halt_code   = halt_code_q;
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign state       = state_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_npc_mc_sequencer.sv
// Bench for npc_mc_sequencer: hand-derived vector table, randomized instructions
// against a cycle-count model, and hand-written reset/watchdog sequences.
module tb_npc_mc_sequencer;
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int          T_A = 8;
    localparam int          T_B = 4;

    typedef struct {
        int          kind;   // 0 alu, 1 load, 2 store, 3 ebreak, 4 illegal, 5 ebreak+illegal
        bit          rd_wen;
        int          ia, ib; // fetch: ready after ia request cycles, rvalid ib cycles after accept
        int          ma, mb; // same for data memory
        logic [31:0] dnpc;
        logic [31:0] inst;
    } desc_t;

    typedef struct {
        desc_t d;
        int    len;          // commit cycle, or last cycle before HALT
        bit    gwen;
        bit    hlt;
        int    code;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst_b = 1'b1;
    logic        ifu_ready = 0, ifu_rvalid = 0, lsu_ready = 0, lsu_rvalid = 0;
    logic [31:0] ifu_rdata = '0, dnpc = '0;
    logic        idu_is_load = 0, idu_is_store = 0, idu_is_ebreak = 0, idu_illegal = 0, idu_rd_wen = 0;

    logic        ifu_req_a, lsu_req_a, lsu_wen_a, gpr_wen_a, commit_a, halt_a;
    logic [31:0] pc_a, inst_a;
    logic [1:0]  halt_code_a;
    logic [2:0]  state_a;
    logic [63:0] cycle_cnt_a, instret_cnt_a;

    logic        ifu_req_b, lsu_req_b, lsu_wen_b, gpr_wen_b, commit_b, halt_b;
    logic [31:0] pc_b, inst_b;
    logic [1:0]  halt_code_b;
    logic [2:0]  state_b;
    logic [63:0] cycle_cnt_b, instret_cnt_b;

    npc_mc_sequencer #(.TIMEOUT(T_A)) dut_a (
        .clk(clk), .rst(rst), .ifu_req(ifu_req_a), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid),
        .ifu_rdata(ifu_rdata), .idu_is_load(idu_is_load), .idu_is_store(idu_is_store),
        .idu_is_ebreak(idu_is_ebreak), .idu_illegal(idu_illegal), .idu_rd_wen(idu_rd_wen),
        .dnpc(dnpc), .lsu_req(lsu_req_a), .lsu_wen(lsu_wen_a), .lsu_ready(lsu_ready),
        .lsu_rvalid(lsu_rvalid), .pc(pc_a), .inst(inst_a), .gpr_wen(gpr_wen_a), .commit(commit_a),
        .halt(halt_a), .halt_code(halt_code_a), .state(state_a), .cycle_cnt(cycle_cnt_a),
        .instret_cnt(instret_cnt_a)
    );

    npc_mc_sequencer #(.TIMEOUT(T_B)) dut_b (
        .clk(clk), .rst(rst_b), .ifu_req(ifu_req_b), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid),
        .ifu_rdata(ifu_rdata), .idu_is_load(idu_is_load), .idu_is_store(idu_is_store),
        .idu_is_ebreak(idu_is_ebreak), .idu_illegal(idu_illegal), .idu_rd_wen(idu_rd_wen),
        .dnpc(dnpc), .lsu_req(lsu_req_b), .lsu_wen(lsu_wen_b), .lsu_ready(lsu_ready),
        .lsu_rvalid(lsu_rvalid), .pc(pc_b), .inst(inst_b), .gpr_wen(gpr_wen_b), .commit(commit_b),
        .halt(halt_b), .halt_code(halt_code_b), .state(state_b), .cycle_cnt(cycle_cnt_b),
        .instret_cnt(instret_cnt_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    longint      m_ret, m_cyc;

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=0x%0h expected=0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        ifu_ready = 0; ifu_rvalid = 0; lsu_ready = 0; lsu_rvalid = 0;
    endtask

    task automatic apply_hints(input int kind, input bit rdw);
        idu_is_load   = (kind == 1);
        idu_is_store  = (kind == 2);
        idu_is_ebreak = (kind == 3 || kind == 5);
        idu_illegal   = (kind == 4 || kind == 5);
        idu_rd_wen    = rdw;
    endtask

    // Cycle within a wait phase at which the watchdog fires, or 0. Progress happens only on the
    // accept cycle (a+1) and the response cycle (a+1+b); a quiet cycle at or past T halts.
    function automatic int phase_timeout(input int a, input int b, input int t);
        int l;
        l = a + 1 + b;
        if (t == 0) return 0;
        for (int k = 1; k <= l; k++)
            if (k >= t && k != a + 1 && k != l) return k;
        return 0;
    endfunction

    function automatic void model(input desc_t d, input int t, output int len, output bit gwen,
                                  output bit hlt, output int code);
        int k, lf;
        gwen = 0; hlt = 0; code = 0;
        lf = d.ia + 1 + d.ib;
        k = phase_timeout(d.ia, d.ib, t);
        if (k != 0) begin
            len = k; hlt = 1; code = 2;
        end else if (d.kind == 3 || d.kind == 5) begin
            len = lf + 1; hlt = 1; code = 0;
        end else if (d.kind == 4) begin
            len = lf + 1; hlt = 1; code = 1;
        end else if (d.kind == 1 || d.kind == 2) begin
            k = phase_timeout(d.ma, d.mb, t);
            if (k != 0) begin
                len = lf + 1 + k; hlt = 1; code = 2;
            end else begin
                len  = lf + 1 + (d.ma + 1 + d.mb) + 1;
                gwen = d.rd_wen && (d.kind != 2);
            end
        end else begin
            len  = lf + 2;
            gwen = d.rd_wen;
        end
    endfunction

    function automatic vec_t mk(input int kind, input bit rdw, input int ia, input int ib, input int ma,
                                input int mb, input int len, input bit gw, input bit h, input int code);
        vec_t v;
        v.d.kind = kind; v.d.rd_wen = rdw;
        v.d.ia = ia; v.d.ib = ib; v.d.ma = ma; v.d.mb = mb;
        v.d.dnpc = $urandom() & 32'hffff_fffc;
        v.d.inst = $urandom();
        v.len = len; v.gwen = gw; v.hlt = h; v.code = code;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1;
        clear_mem();
        apply_hints(0, 0);
        tick();
        tick();
        chk("rst", "state_in_rst", 64'(state_a), 64'(0));
        chk("rst", "ifu_req_in_rst", 64'(ifu_req_a), 64'(0));
        chk("rst", "halt_in_rst", 64'(halt_a), 64'(0));
        rst = 0;
        #1;
        chk("rst", "ifu_req", 64'(ifu_req_a), 64'(1));
        chk("rst", "pc", 64'(pc_a), 64'(RPC));
        chk("rst", "inst", 64'(inst_a), 64'(0));
        chk("rst", "cycle_cnt", cycle_cnt_a, 64'(0));
        chk("rst", "instret", instret_cnt_a, 64'(0));
        chk("rst", "halt_code", 64'(halt_code_a), 64'(0));
        m_pc = RPC; m_ret = 0; m_cyc = 0;
    endtask

    // HALT must stay quiet for 20 cycles even with memories shouting at it
    task automatic halt_hold(input string tag, input longint cyc0);
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ifu_ready = 1; ifu_rvalid = 1; lsu_ready = 1; lsu_rvalid = 1;
            if (ifu_req_a || lsu_req_a || commit_a || gpr_wen_a || !halt_a) bad++;
            tick();
        end
        clear_mem();
        chk(tag, "halt_quiet", 64'(bad), 64'(0));
        chk(tag, "halt_cycle_cnt", cycle_cnt_a, 64'(cyc0 + 20));
        chk(tag, "halt_pc", 64'(pc_a), 64'(m_pc));
    endtask

    task automatic run_and_check(input string tag, input desc_t d, input int e_len, input bit e_gwen,
                                 input bit e_hlt, input int e_code);
        bit          if_acc, mem_acc, wen_bad, gw_stray, done, got_commit, got_halt, got_gwen;
        int          if_req_n, mem_req_n, if_cnt, mem_cnt, t_obs, hcode;
        logic [31:0] got_inst;
        if_acc = 0; mem_acc = 0; wen_bad = 0; gw_stray = 0; done = 0;
        got_commit = 0; got_halt = 0; got_gwen = 0; got_inst = '0;
        if_req_n = 0; mem_req_n = 0; if_cnt = 0; mem_cnt = 0; t_obs = 0; hcode = 0;
        apply_hints(d.kind, d.rd_wen);
        ifu_rdata = d.inst;
        dnpc = d.dnpc;
        for (int t = 1; t <= 120 && !done; t++) begin
            clear_mem();
            if (halt_a) begin
                got_halt = 1; t_obs = t; hcode = int'(halt_code_a); done = 1;
            end else begin
                if (ifu_req_a) begin
                    if (if_req_n == d.ia) begin
                        ifu_ready = 1; if_acc = 1;
                        if (d.ib == 0) ifu_rvalid = 1;
                    end
                    if_req_n++;
                end else if (if_acc) begin
                    if_cnt++;
                    if (if_cnt == d.ib) ifu_rvalid = 1;
                end
                if (lsu_req_a) begin
                    if (lsu_wen_a !== (d.kind == 2)) wen_bad = 1;
                    if (mem_req_n == d.ma) begin
                        lsu_ready = 1; mem_acc = 1;
                        if (d.mb == 0) lsu_rvalid = 1;
                    end
                    mem_req_n++;
                end else if (mem_acc) begin
                    mem_cnt++;
                    if (mem_cnt == d.mb) lsu_rvalid = 1;
                end
                if (commit_a) begin
                    got_commit = 1; t_obs = t; got_gwen = gpr_wen_a; got_inst = inst_a;
                end else if (gpr_wen_a) begin
                    gw_stray = 1;
                end
                tick();
                if (got_commit) done = 1;
            end
        end
        clear_mem();
        $display("%s kind=%0d rd=%0d ia=%0d ib=%0d ma=%0d mb=%0d len=%0d halt=%0d code=%0d t=%0d",
                 tag, d.kind, d.rd_wen, d.ia, d.ib, d.ma, d.mb, e_len, e_hlt, e_code, t_obs);
        chk(tag, "halt", 64'(got_halt), 64'(e_hlt));
        chk(tag, "gpr_wen_outside_wb", 64'(gw_stray), 64'(0));
        if (e_hlt) begin
            chk(tag, "halt_cycle", 64'(t_obs - 1), 64'(e_len));
            chk(tag, "halt_code", 64'(hcode), 64'(e_code));
            chk(tag, "pc_frozen", 64'(pc_a), 64'(m_pc));
            chk(tag, "cycle_at_halt", cycle_cnt_a, 64'(m_cyc + longint'(t_obs) - 1));
            halt_hold(tag, m_cyc + longint'(t_obs) - 1);
            do_reset();
        end else begin
            chk(tag, "commit_seen", 64'(got_commit), 64'(1));
            chk(tag, "commit_cycle", 64'(t_obs), 64'(e_len));
            chk(tag, "gpr_wen", 64'(got_gwen), 64'(e_gwen));
            chk(tag, "inst", 64'(got_inst), 64'(d.inst));
            chk(tag, "pc_next", 64'(pc_a), 64'(d.dnpc));
            chk(tag, "instret", instret_cnt_a, 64'(m_ret + 1));
            chk(tag, "cycle_cnt", cycle_cnt_a, 64'(m_cyc + longint'(e_len)));
            chk(tag, "ifu_req_cycles", 64'(if_req_n), 64'(d.ia + 1));
            if (d.kind == 1 || d.kind == 2) begin
                chk(tag, "lsu_req_cycles", 64'(mem_req_n), 64'(d.ma + 1));
                chk(tag, "lsu_wen", 64'(wen_bad), 64'(0));
            end
            m_pc = d.dnpc; m_ret++; m_cyc += longint'(e_len);
            if (got_halt || !got_commit) do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t  tbl[14];
        desc_t d;
        int    len, code, r, bad;
        bit    gw, h, big;

        tbl[0]  = mk(0, 1, 0, 0, 0, 0,  3, 1, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 2, 3,  9, 1, 0, 0);
        tbl[2]  = mk(2, 1, 1, 2, 0, 0,  7, 0, 0, 0);
        tbl[3]  = mk(0, 0, 2, 1, 0, 0,  6, 0, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 0,  4, 1, 0, 0);
        tbl[5]  = mk(0, 1, 3, 4, 0, 0, 10, 1, 0, 0);
        tbl[6]  = mk(4, 1, 0, 1, 0, 0,  3, 0, 1, 1);
        tbl[7]  = mk(0, 1, 3, 5, 0, 0,  8, 0, 1, 2);
        tbl[8]  = mk(5, 1, 0, 0, 0, 0,  2, 0, 1, 0);
        tbl[9]  = mk(1, 1, 0, 0, 7, 0, 11, 1, 0, 0);
        tbl[10] = mk(2, 0, 0, 0, 8, 0, 10, 0, 1, 2);
        tbl[11] = mk(3, 0, 0, 0, 0, 0,  2, 0, 1, 0);
        tbl[12] = mk(0, 1, 7, 1, 0, 0, 11, 1, 0, 0);
        tbl[13] = mk(0, 1, 6, 2, 0, 0,  8, 0, 1, 2);

        do_reset();
        for (int i = 0; i < 14; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].len, tbl[i].gwen, tbl[i].hlt, tbl[i].code);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            d.kind = (r < 9) ? 0 : (r < 13) ? 1 : (r < 17) ? 2 : 3 + int'($urandom_range(0, 2));
            d.rd_wen = 1'($urandom_range(0, 1));
            big = ($urandom_range(0, 7) == 0);
            d.ia = int'($urandom_range(0, big ? 8 : 3));
            d.ib = int'($urandom_range(0, big ? 8 : 3));
            d.ma = int'($urandom_range(0, big ? 8 : 3));
            d.mb = int'($urandom_range(0, big ? 8 : 3));
            d.dnpc = $urandom() & 32'hffff_fffc;
            d.inst = $urandom();
            model(d, T_A, len, gw, h, code);
            run_and_check($sformatf("rnd%0d", n), d, len, gw, h, code);
        end

        // Reset in MEM_WAIT, then a stale data response must not retire anything
        do_reset();
        apply_hints(1, 1);
        ifu_rdata = 32'h0000_2083;
        dnpc = 32'h8000_0004;
        ifu_ready = 1; ifu_rvalid = 1;
        tick();
        clear_mem();
        chk("mw", "exec", 64'(state_a), 64'(2));
        tick();
        chk("mw", "mem_req", 64'(state_a), 64'(3));
        lsu_ready = 1;
        tick();
        lsu_ready = 0;
        chk("mw", "mem_wait", 64'(state_a), 64'(4));
        rst = 1;
        tick();
        chk("mw", "state_after_rst", 64'(state_a), 64'(0));
        chk("mw", "pc_after_rst", 64'(pc_a), 64'(RPC));
        chk("mw", "inst_after_rst", 64'(inst_a), 64'(0));
        chk("mw", "cycle_after_rst", cycle_cnt_a, 64'(0));
        chk("mw", "instret_after_rst", instret_cnt_a, 64'(0));
        rst = 0;
        lsu_rvalid = 1;
        #1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (commit_a || gpr_wen_a || state_a != 3'd0) bad++;
            tick();
            lsu_rvalid = 0;
        end
        $display("mw reset-in-mem-wait late_rvalid_violations=%0d", bad);
        chk("mw", "late_rvalid_ignored", 64'(bad), 64'(0));
        chk("mw", "instret_still_0", instret_cnt_a, 64'(0));

        // Watchdog on the TIMEOUT=4 instance; the A instance is parked in reset
        rst = 1;
        rst_b = 1;
        clear_mem();
        apply_hints(0, 1);
        tick();
        tick();
        rst_b = 0;
        #1;
        for (int c = 1; c <= T_B; c++) begin
            chk("wd", $sformatf("no_halt_c%0d", c), 64'(halt_b), 64'(0));
            chk("wd", $sformatf("ifreq_c%0d", c), 64'(state_b), 64'(0));
            tick();
        end
        $display("wd timeout run halt=%0d code=%0d", halt_b, halt_code_b);
        chk("wd", "halt", 64'(halt_b), 64'(1));
        chk("wd", "halt_code", 64'(halt_code_b), 64'(2));
        chk("wd", "state_halt", 64'(state_b), 64'(7));

        rst_b = 1;
        tick();
        tick();
        rst_b = 0;
        #1;
        tick();
        tick();
        tick();
        ifu_ready = 1; ifu_rvalid = 1;
        tick();
        clear_mem();
        $display("wd rvalid-on-4th run halt=%0d state=%0d", halt_b, state_b);
        chk("wd2", "no_halt", 64'(halt_b), 64'(0));
        chk("wd2", "exec", 64'(state_b), 64'(2));
        tick();
        chk("wd2", "commit", 64'(commit_b), 64'(1));
        rst_b = 1;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/npc_mc_sequencer.md
Name: npc_mc_sequencer

Overview:
Multi-cycle control core for the NPC. It replaces single-cycle combinational chaining with an FSM that sequences fetch, execute, memory and writeback through valid/ready handshakes to instruction and data memory. The block owns the PC, instruction latch, commit strobes, halt detection and performance counters. Decode and execute remain external: IDU/EXU/WBU drive the hint inputs and dnpc.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h8000_0000, PC value loaded on reset
CNT_W, 64, width of cycle and instret counters
TIMEOUT, 1023, max wait cycles for a memory response; 0 disables the watchdog

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ifu_req  output  1  fetch request, held until accepted
ifu_ready  input  1  imem accepts request
ifu_rvalid  input  1  one-cycle fetch response strobe
ifu_rdata  input  32  fetched instruction
idu_is_load  input  1  current inst is a load
idu_is_store  input  1  current inst is a store
idu_is_ebreak  input  1  current inst is ebreak
idu_illegal  input  1  decode failed
idu_rd_wen  input  1  inst writes rd
dnpc  input  XLEN  next PC from WBU
lsu_req  output  1  data request, held until accepted
lsu_wen  output  1  request is a store; valid with lsu_req
lsu_ready  input  1  dmem accepts request
lsu_rvalid  input  1  one-cycle data response strobe (loads and stores)
pc  output  XLEN  current PC
inst  output  32  latched instruction
gpr_wen  output  1  register write enable, WB cycle only
commit  output  1  one-cycle pulse per retired instruction
halt  output  1  sticky halt
halt_code  output  2  0 ebreak, 1 illegal, 2 timeout
state  output  3  FSM state encoding, for debug
cycle_cnt  output  CNT_W  cycles since reset
instret_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset values: pc=RESET_PC, inst=0, state=IF_REQ, all request, strobe and halt outputs 0, halt_code=0, counters 0. Reset overrides any state, including mid-handshake. Outstanding responses arriving after reset are ignored until a new request is accepted.
- State encodings: IF_REQ=0, IF_WAIT=1, EXEC=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=7.
- IF_REQ: ifu_req=1. On ifu_ready, go to IF_WAIT. If ifu_rvalid also fires in the same cycle, latch inst and go directly to EXEC.
- IF_WAIT: ifu_req=0. On ifu_rvalid, inst<=ifu_rdata and go to EXEC.
- EXEC (exactly 1 cycle; hints are sampled here):
  - ebreak takes priority over illegal: HALT, code 0.
  - else illegal: HALT, code 1.
  - else load or store: MEM_REQ.
  - else: WB.
- MEM_REQ: lsu_req=1 and lsu_wen=idu_is_store. Acceptance and same-cycle response follow the fetch rules, going to MEM_WAIT or WB.
- MEM_WAIT: on lsu_rvalid, go to WB.
- WB (1 cycle):
  - gpr_wen=idu_rd_wen; stores force gpr_wen=0.
  - commit=1, pc<=dnpc, instret_cnt+1, then IF_REQ.
- Minimum latency with 0-wait memory: 3 cycles for ALU instructions (IF_REQ, EXEC, WB) and 4 for loads/stores.
- Watchdog:
  - A wait counter clears on entry to IF_REQ or MEM_REQ and increments each cycle in IF_REQ, IF_WAIT, MEM_REQ and MEM_WAIT.
  - When the counter reaches TIMEOUT (TIMEOUT≠0), go to HALT with code 2 on the next edge.
  - A response arriving in the same cycle as the timeout wins.
- HALT: halt=1, sticky until rst. No requests, no gpr_wen, no commit; pc is frozen.
- Counters:
  - cycle_cnt increments every non-reset cycle, including in HALT.
  - Both counters wrap modulo 2^CNT_W.
- Requests are never withdrawn before acceptance.

Test Plan:
- rst held 2 cycles, then released with an ALU inst, ifu_ready=1 and same-cycle rvalid → pc=8000_0000; commit at cycle 3; pc=dnpc=8000_0004; instret=1; cycle_cnt=3.
- Load with lsu_ready delayed 2 cycles and rvalid 3 cycles after acceptance → lsu_req held 3 cycles; gpr_wen=1 in WB only; commit 1 cycle later.
- Store with idu_rd_wen=1 → lsu_wen=1 during MEM_REQ; gpr_wen=0 in WB; commit=1.
- ebreak and illegal both asserted in EXEC → halt=1, halt_code=0; no further ifu_req for 20 cycles; cycle_cnt keeps counting.
- TIMEOUT=4 and imem never responding → halt with code 2 exactly 4 cycles after entering IF_REQ; second run with rvalid on the 4th cycle → no halt.
- rst asserted during MEM_WAIT → next cycle state=IF_REQ, pc=8000_0000, counters 0; a late lsu_rvalid causes no commit.
